// File: rtl/log_div_k_pipe.sv
// log_div_k_pipe: 3-stage logarithmic approximate divider a/b*2^N with global-stall handshake
module log_div_k_pipe #(
  parameter int N     = 8,
  parameter int LOG_N = 3,
  parameter int K     = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] z,
  output logic           div_by_zero,
  output logic           busy
);
  localparam int L = LOG_N + K;

  logic               en;
  logic [LOG_N-1:0]   ka, kb;
  logic [K-1:0]       fa, fb;
  logic [LOG_N+1:0]   sh;
  logic [2*N+K-1:0]   w;
  logic               s1_v_q, s1_v_d, s1_az_q, s1_az_d, s1_bz_q, s1_bz_d;
  logic [L-1:0]       s1_la_q, s1_la_d, s1_lb_q, s1_lb_d;
  logic               s2_v_q, s2_v_d, s2_az_q, s2_az_d, s2_bz_q, s2_bz_d;
  logic [L:0]         s2_d_q, s2_d_d;
  logic               s3_v_q, s3_v_d, dz_q, dz_d;
  logic [2*N-1:0]     z_q, z_d;

  function automatic logic [LOG_N-1:0] lod(input logic [N-1:0] x);
    lod = '0;
    for (int i = 0; i < N; i++) if (x[i]) lod = LOG_N'(i);
  endfunction

  assign en          = ~(s3_v_q & ~out_ready);
  assign in_ready    = en;
  assign out_valid   = s3_v_q;
  assign z           = z_q;
  assign div_by_zero = dz_q;
  assign busy        = s1_v_q | s2_v_q | s3_v_q;

  // leading-one position and the K bits just below it for both operands
  always_comb begin
    ka = lod(a);
    kb = lod(b);
    fa = K'((a << (N - 1 - int'(ka))) >> (N - 1 - K));
    fb = K'((b << (N - 1 - int'(kb))) >> (N - 1 - K));
  end

  // antilog: restore the hidden one above f and shift by N+e, dropping K fraction bits
  always_comb begin
    sh = (LOG_N+2)'(N) + (LOG_N+2)'($signed(s2_d_q[L:K]));
    w  = (2*N+K)'({1'b1, s2_d_q[K-1:0]}) << sh;
  end

  // next state of every stage; the whole pipe freezes while the output is blocked
  always_comb begin
    s1_v_d  = en ? in_valid : s1_v_q;
    s1_la_d = en ? {ka, fa} : s1_la_q;
    s1_lb_d = en ? {kb, fb} : s1_lb_q;
    s1_az_d = en ? (a == '0) : s1_az_q;
    s1_bz_d = en ? (b == '0) : s1_bz_q;
    s2_v_d  = en ? s1_v_q : s2_v_q;
    s2_d_d  = en ? {1'b0, s1_la_q} - {1'b0, s1_lb_q} : s2_d_q;
    s2_az_d = en ? s1_az_q : s2_az_q;
    s2_bz_d = en ? s1_bz_q : s2_bz_q;
    s3_v_d  = en ? s2_v_q : s3_v_q;
    z_d     = en ? (s2_bz_q ? '1 : s2_az_q ? '0 : (2*N)'(w >> K)) : z_q;
    dz_d    = en ? s2_bz_q : dz_q;
  end

  // stage registers with synchronous reset that drops all in-flight work
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q  <= 1'b0;
      s1_la_q <= '0;
      s1_lb_q <= '0;
      s1_az_q <= 1'b0;
      s1_bz_q <= 1'b0;
      s2_v_q  <= 1'b0;
      s2_d_q  <= '0;
      s2_az_q <= 1'b0;
      s2_bz_q <= 1'b0;
      s3_v_q  <= 1'b0;
      z_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      s1_v_q  <= s1_v_d;
      s1_la_q <= s1_la_d;
      s1_lb_q <= s1_lb_d;
      s1_az_q <= s1_az_d;
      s1_bz_q <= s1_bz_d;
      s2_v_q  <= s2_v_d;
      s2_d_q  <= s2_d_d;
      s2_az_q <= s2_az_d;
      s2_bz_q <= s2_bz_d;
      s3_v_q  <= s3_v_d;
      z_q     <= z_d;
      dz_q    <= dz_d;
    end
  end
endmodule

// File: tb/tb_log_div_k_pipe.sv
// tb_log_div_k_pipe: directed and random checks of log_div_k_pipe against an arithmetic model
module tb_log_div_k_pipe;
  localparam int N = 8;
  localparam int LOG_N = 3;
  localparam int K = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b1;
  logic [N-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic           in_ready, out_valid, div_by_zero, busy;
  logic [2*N-1:0] z;

  typedef struct {
    logic [2*N-1:0] z;
    logic           dz;
    int             cnt;
  } ent_t;

  ent_t           q[$];
  int             n_chk = 0;
  int             n_fail = 0;
  bit             fired, accepted, hold_q, saw_stall, exp_ov;
  logic [2*N-1:0] last_z, hold_z;
  logic           last_dz, hold_dz;
  logic [N-1:0]   sa [5] = '{8'd8, 8'd2, 8'd3, 8'd12, 8'd255};
  logic [N-1:0]   sb [5] = '{8'd2, 8'd3, 8'd2, 8'd4, 8'd0};

  log_div_k_pipe #(.N(N), .LOG_N(LOG_N), .K(K)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t model(input logic [N-1:0] x, input logic [N-1:0] y);
    ent_t r;
    int ka, kb, fa, fb, d, e, f;
    longint w;
    r.cnt = 0;
    r.dz = 1'b0;
    r.z = '0;
    if (y == 0) begin
      r.z = '1;
      r.dz = 1'b1;
    end else if (x != 0) begin
      ka = 0;
      kb = 0;
      for (int i = 0; i < N; i++) begin
        if (x[i]) ka = i;
        if (y[i]) kb = i;
      end
      fa = ((int'(x) - (1 << ka)) << K) >> ka;
      fb = ((int'(y) - (1 << kb)) << K) >> kb;
      d = (ka * (1 << K) + fa) - (kb * (1 << K) + fb);
      e = d >>> K;
      f = d & ((1 << K) - 1);
      w = longint'((1 << K) + f) << (N + e);
      r.z = (2*N)'(w >> K);
    end
    return r;
  endfunction

  task automatic tick();
    #1;
    fired = 0;
    accepted = 0;
    if (!rst) begin
      exp_ov = q.size() > 0 && q[0].cnt == 3;
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("busy", 32'(busy), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(!(exp_ov && !out_ready)));
      if (hold_q) begin
        chk("hold_z", 32'(z), 32'(hold_z));
        chk("hold_dz", 32'(div_by_zero), 32'(hold_dz));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", 32'(out_valid), 32'(0));
        else begin
          chk("z", 32'(z), 32'(q[0].z));
          chk("dz", 32'(div_by_zero), 32'(q[0].dz));
          last_z = z;
          last_dz = div_by_zero;
          fired = 1;
          void'(q.pop_front());
        end
      end
      hold_q = out_valid && !out_ready;
      hold_z = z;
      hold_dz = div_by_zero;
      if (in_valid && in_ready) begin
        q.push_back(model(a, b));
        accepted = 1;
      end
      if (in_ready) foreach (q[i]) q[i].cnt++;
      if (!in_ready) saw_stall = 1;
    end else begin
      q.delete();
      hold_q = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_one(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                        input logic [2*N-1:0] ez, input logic edz);
    int n;
    a = x;
    b = y;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    chk({tag, "_acc"}, 32'(accepted), 32'(1));
    in_valid = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!fired && n < 10);
    chk({tag, "_lat"}, 32'(n), 32'(3));
    chk({tag, "_z"}, 32'(last_z), 32'(ez));
    chk({tag, "_dz"}, 32'(last_dz), 32'(edz));
  endtask

  initial begin
    int idx, got, nacc, cyc;
    rst = 1'b1;
    in_valid = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_z", 32'(z), 32'(0));
    chk("rst_dz", 32'(div_by_zero), 32'(0));
    chk("rst_ready", 32'(in_ready), 32'(1));
    tick();

    do_one("pow", 8'd8, 8'd2, 16'd1024, 1'b0);
    do_one("frac23", 8'd2, 8'd3, 16'd192, 1'b0);
    do_one("frac32", 8'd3, 8'd2, 16'd384, 1'b0);
    do_one("frac124", 8'd12, 8'd4, 16'd768, 1'b0);
    do_one("max", 8'd255, 8'd1, 16'd64512, 1'b0);
    do_one("zero_a", 8'd0, 8'd5, 16'd0, 1'b0);
    do_one("div0", 8'd7, 8'd0, 16'hFFFF, 1'b1);
    do_one("div00", 8'd0, 8'd0, 16'hFFFF, 1'b1);

    idx = 0;
    got = 0;
    saw_stall = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = idx < 5;
      a = sa[idx % 5];
      b = sb[idx % 5];
      out_ready = !(c >= 4 && c <= 6);
      tick();
      if (accepted) idx++;
      if (fired) got++;
    end
    chk("stream_got", 32'(got), 32'(5));
    chk("stream_stall", 32'(saw_stall), 32'(1));

    in_valid = 1'b1;
    out_ready = 1'b1;
    a = 8'd100;
    b = 8'd7;
    tick();
    a = 8'd50;
    tick();
    in_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    do_one("post_rst", 8'd8, 8'd2, 16'd1024, 1'b0);

    nacc = 0;
    cyc = 0;
    while (nacc < 10000 && cyc < 60000) begin
      in_valid = $urandom_range(0, 3) != 0;
      a = ($urandom_range(0, 15) == 0) ? '0 : N'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      tick();
      if (accepted) nacc++;
      cyc++;
    end
    chk("rand_count", 32'(nacc), 32'(10000));
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() > 0; c++) tick();
    chk("drain_busy", 32'(busy), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
